// File: rtl/count_seq_ctrl.sv
// Sequencer for an external loadable up/down counter: load, run to end value, then finish or reload.
// Load strobe one cycle after an accepted start; done pulses the cycle after the terminal event.
module count_seq_ctrl #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         stop,
  input  logic         hold,
  input  logic         mode_down,
  input  logic         one_shot,
  input  logic [N-1:0] start_val,
  input  logic [N-1:0] end_val,
  input  logic [N-1:0] ctr_count,
  output logic         ctr_load,
  output logic         ctr_en,
  output logic         ctr_up_down,
  output logic [N-1:0] ctr_d,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] evt_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] start_sh, end_sh;
  logic         dir_sh, one_shot_sh;
  logic         accept, term, at_end;

  assign at_end      = (ctr_count == end_sh);
  assign ctr_up_down = dir_sh;
  assign ctr_d       = start_sh;

  always_comb begin
    state_nxt = state;
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    accept    = 1'b0;
    term      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          ctr_load  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // stop outranks a terminal event landing in the same cycle
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          ctr_en = ~hold & ~at_end;
          if (at_end) begin
            term      = 1'b1;
            state_nxt = one_shot_sh ? IDLE : LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      start_sh    <= '0;
      end_sh      <= '0;
      dir_sh      <= 1'b0;
      one_shot_sh <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      evt_cnt     <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= term & one_shot_sh;
      if (accept) begin
        start_sh    <= start_val;
        end_sh      <= end_val;
        dir_sh      <= mode_down;
        one_shot_sh <= one_shot;
        evt_cnt     <= '0;
      end else if (term && (evt_cnt != {W{1'b1}})) begin
        evt_cnt <= evt_cnt + 1'b1;
      end
    end
  end

endmodule
